vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Timing master for the VGA path. Generates raster position pixel_x/pixel_y, active video, hsync and vsync.
//  Default timing: 800x600@72 Hz, pixel rate 50 MHz.
//  Drives every sprite/address generator (barrier, player, ball), which compare pixel_x/pixel_y against fixed rows/columns.
//  Also produces line/frame strobes for game-logic update timing.
// PARAMETERS
//  H_ACTIVE 800  visible pixels per line
//  H_FRONT  56   horizontal front porch, in pixels
//  H_SYNC   120  hsync width, in pixels
//  H_BACK   64   horizontal back porch; H_TOTAL = 1040
//  V_ACTIVE 600  visible lines per frame
//  V_FRONT  37   vertical front porch, in lines
//  V_SYNC   6    vsync width, in lines
//  V_BACK   23   vertical back porch; V_TOTAL = 666
//  SYNC_POL 1    asserted level of hsync/vsync (1 = positive)
// PORTS
//  clk          in   1   system clock; all state updates on posedge
//  reset        in   1   asynchronous, active-high reset
//  pix_ce       in   1   pixel clock enable; raster advances only when high
//  pixel_x      out  11  current column, 0..H_TOTAL-1
//  pixel_y      out  10  current row, 0..V_TOTAL-1
//  active       out  1   high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
//  hsync        out  1   horizontal sync, polarity per SYNC_POL
//  vsync        out  1   vertical sync, polarity per SYNC_POL
//  line_start   out  1   one-cycle strobe when pixel_x becomes 0
//  frame_start  out  1   one-cycle strobe when (pixel_x,pixel_y) becomes (0,0)
//  frame_count  out  16  frames since reset (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, active=0, hsync=vsync=~SYNC_POL, strobes=0, frame_count=0.
//    The first pix_ce after reset therefore wraps to (0,0) and raises frame_start.
//  - All outputs are registered and mutually aligned: active/hsync/vsync/strobes describe the pixel_x/pixel_y
//    shown in the same cycle. They are computed from the next-count values, so there is no extra latency.
//  - On posedge with pix_ce=1:
//    - pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments.
//    - pixel_y wraps V_TOTAL-1 -> 0 only when pixel_x also wraps.
//  - pix_ce=0: counters and levels hold; line_start/frame_start forced 0 (a strobe is one cycle max, only on a ce cycle).
//  - Per-axis phase FSM: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
//    - Transitions happen at counts ACTIVE_END, FRONT_END, SYNC_END and TOTAL-1.
//    - hsync asserted iff the H-FSM is in SYNC: pixel_x 856..975.
//    - vsync asserted iff the V-FSM is in SYNC: pixel_y 637..642.
//  - The V-FSM advances only on the pixel_x wrap cycle; vsync edges coincide with pixel_x=0.
//  - pixel_x==H_ACTIVE-1 (799) occurs exactly once per line, including blanking lines; consumers rely on this.
//  - Width rule: counters never exceed TOTAL-1. Totals wider than 11/10 bits are illegal (elaboration error).
//  - Reset mid-frame: immediate return to reset values; no partial strobe.
// CONFIGURATION
//  VGA_FRAME_COUNT_EN defined:
//   - frame_count increments by 1 on every frame_start cycle.
//   - Wraps 0xFFFF -> 0.
//  Not defined:
//   - frame_count is tied to 16'd0.
//   - No counter register is synthesised.
// STRUCTURE
//  - Shared include vga_timing.vh:
//    - default H_/V_ timing localparams, H_TOTAL, V_TOTAL, phase encodings (PH_ACTIVE..PH_BACK, 2 bits)
//    - the screen localparams SCREEN_W=800 and SCREEN_H=600, also used by sprite blocks
//  - Sub-module vga_axis_counter(WIDTH, ACTIVE, FRONT, SYNC, BACK):
//    - holds count + phase FSM, with input step and outputs count, wrap, in_active, in_sync
//    - instantiated twice: horizontal with step=pix_ce; vertical with step=pix_ce & h_wrap.
// TESTING
//  1 Assert reset, no ce -> pixel_x=1039, pixel_y=665, active=0, hsync=vsync=0, frame_count=0.
//  2 Release reset, one pix_ce -> (0,0), active=1, line_start=frame_start=1; next ce -> both strobes 0.
//  3 Run line 0 -> active falls at pixel_x 799->800; hsync high at 856..975 only; 1039 -> (0,1) with line_start.
//  4 Run a full frame -> vsync high for rows 637..642 and rises at pixel_x=0; 665/1039 -> (0,0) with frame_start.
//    With VGA_FRAME_COUNT_EN, frame_count=1.
//  5 Hold pix_ce=0 for 10 cycles at pixel_x=1039 -> all outputs hold and no strobes.
//    On the next ce, wrap occurs exactly once.
//  6 Assert reset at (400,300) mid-line -> immediate reset values asynchronously, no frame_start until the first ce after release.

Source files
------------

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants (800x600@72 Hz defaults), screen size and axis phase encoding.
// Imported by the sync generator and by sprite/address generators that need SCREEN_W/SCREEN_H.
package vga_sync_gen_pkg;

   localparam int unsigned DEF_H_ACTIVE = 800;
   localparam int unsigned DEF_H_FRONT  = 56;
   localparam int unsigned DEF_H_SYNC   = 120;
   localparam int unsigned DEF_H_BACK   = 64;

   localparam int unsigned DEF_V_ACTIVE = 600;
   localparam int unsigned DEF_V_FRONT  = 37;
   localparam int unsigned DEF_V_SYNC   = 6;
   localparam int unsigned DEF_V_BACK   = 23;

   localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int unsigned SCREEN_W = 800;
   localparam int unsigned SCREEN_H = 600;

   localparam int unsigned X_WIDTH = 11;
   localparam int unsigned Y_WIDTH = 10;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_sync_gen_axis.sv
// One raster axis: wrapping counter plus ACTIVE->FRONT->SYNC->BACK phase FSM.
// wrap/in_active/in_sync describe the count that takes effect at the coming clock edge.
module vga_axis_counter
   import vga_sync_gen_pkg::*;
#(
   parameter int unsigned WIDTH  = 11,
   parameter int unsigned ACTIVE = 800,
   parameter int unsigned FRONT  = 56,
   parameter int unsigned SYNC   = 120,
   parameter int unsigned BACK   = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             in_active,
   output logic             in_sync
);

   localparam int unsigned TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

   localparam logic [WIDTH-1:0] ACTIVE_END = WIDTH'(ACTIVE - 1);
   localparam logic [WIDTH-1:0] FRONT_END  = WIDTH'(ACTIVE + FRONT - 1);
   localparam logic [WIDTH-1:0] SYNC_END   = WIDTH'(ACTIVE + FRONT + SYNC - 1);
   localparam logic [WIDTH-1:0] LAST       = WIDTH'(TOTAL - 1);

   if (TOTAL > (2 ** WIDTH)) begin : g_total_too_wide
      $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, WIDTH);
   end

   if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0) begin : g_empty_phase
      $error("vga_axis_counter: every phase needs at least one count");
   end

   phase_t           phase;
   phase_t           phase_next;
   logic [WIDTH-1:0] count_next;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      count_next = count;
      phase_next = phase;
      wrap       = 1'b0;
      if (step) begin
         if (count == LAST) begin
            count_next = '0;
            wrap       = 1'b1;
         end else begin
            count_next = count + 1'b1;
         end
         unique case (phase)
            PH_ACTIVE: if (count == ACTIVE_END) phase_next = PH_FRONT;
            PH_FRONT:  if (count == FRONT_END)  phase_next = PH_SYNC;
            PH_SYNC:   if (count == SYNC_END)   phase_next = PH_BACK;
            PH_BACK:   if (count == LAST)       phase_next = PH_ACTIVE;
            default:   phase_next = PH_BACK;
         endcase
      end
   end

   assign in_active = (phase_next == PH_ACTIVE);
   assign in_sync   = (phase_next == PH_SYNC);

   // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= LAST;
         phase <= PH_BACK;
      end else begin
         count <= count_next;
         phase <= phase_next;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing master: raster position, active video, hsync/vsync and line/frame strobes.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN; otherwise frame_count is 0.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FRONT  = DEF_H_FRONT,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BACK   = DEF_H_BACK,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT  = DEF_V_FRONT,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BACK   = DEF_V_BACK,
   parameter bit          SYNC_POL = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pix_ce,
   output logic [X_WIDTH-1:0]   pixel_x,
   output logic [Y_WIDTH-1:0]   pixel_y,
   output logic                 active,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 line_start,
   output logic                 frame_start,
   output logic [15:0]          frame_count
);

   logic h_wrap;
   logic h_in_active;
   logic h_in_sync;
   logic v_step;
   logic v_wrap;
   logic v_in_active;
   logic v_in_sync;

   vga_axis_counter #(
      .WIDTH  (X_WIDTH),
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h_axis (
      .clk       (clk),
      .reset     (reset),
      .step      (pix_ce),
      .count     (pixel_x),
      .wrap      (h_wrap),
      .in_active (h_in_active),
      .in_sync   (h_in_sync)
   );

   // The vertical axis moves only on the cycle the line wraps.
   assign v_step = pix_ce & h_wrap;

   vga_axis_counter #(
      .WIDTH  (Y_WIDTH),
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v_axis (
      .clk       (clk),
      .reset     (reset),
      .step      (v_step),
      .count     (pixel_y),
      .wrap      (v_wrap),
      .in_active (v_in_active),
      .in_sync   (v_in_sync)
   );

   // Registered from next-count flags so levels line up with pixel_x/pixel_y.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active      <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         active      <= h_in_active & v_in_active;
         hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
         vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
         line_start  <= h_wrap;
         frame_start <= h_wrap & v_wrap;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_count <= 16'd0;
      end else if (frame_start) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`else
   assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance for line-level checks, small-timing instance for frame wraps.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic reset;
   logic pix_ce;

   always #5 clk = ~clk;

   logic [10:0] px [2];
   logic [9:0]  py [2];
   logic        act [2];
   logic        hs [2];
   logic        vs [2];
   logic        ls [2];
   logic        fs [2];
   logic [15:0] fcnt [2];

   vga_sync_gen dut0 (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .pixel_x(px[0]), .pixel_y(py[0]), .active(act[0]), .hsync(hs[0]), .vsync(vs[0]),
      .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fcnt[0])
   );

   vga_sync_gen #(
      .H_ACTIVE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_ACTIVE(5),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1'b0)
   ) dut1 (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .pixel_x(px[1]), .pixel_y(py[1]), .active(act[1]), .hsync(hs[1]), .vsync(vs[1]),
      .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fcnt[1])
   );

   int unsigned ha [2] = '{800, 10};
   int unsigned hf [2] = '{56, 2};
   int unsigned hw [2] = '{120, 3};
   int unsigned hb [2] = '{64, 2};
   int unsigned va [2] = '{600, 5};
   int unsigned vf [2] = '{37, 2};
   int unsigned vw [2] = '{6, 2};
   int unsigned vb [2] = '{23, 3};
   bit          pol [2] = '{1'b1, 1'b0};

   // Model: linear raster position within the frame, advanced by one per enabled edge.
   int unsigned pos [2];
   int unsigned fcm [2];
   bit          m_ls [2];
   bit          m_fs [2];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit ce;
      int x;
      int y;
      bit a;
      bit h;
      bit v;
      bit l;
      bit f;
   } vec_t;

   function automatic int unsigned ht(input int i);
      return ha[i] + hf[i] + hw[i] + hb[i];
   endfunction

   function automatic int unsigned vt(input int i);
      return va[i] + vf[i] + vw[i] + vb[i];
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         pos[i]  = ht(i) * vt(i) - 1;
         fcm[i]  = 0;
         m_ls[i] = 1'b0;
         m_fs[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input bit ce);
      for (int i = 0; i < 2; i++) begin
         if (m_fs[i]) fcm[i]++;
         m_ls[i] = 1'b0;
         m_fs[i] = 1'b0;
         if (ce) begin
            pos[i]  = (pos[i] + 1) % (ht(i) * vt(i));
            m_ls[i] = (pos[i] % ht(i)) == 0;
            m_fs[i] = pos[i] == 0;
         end
      end
   endtask

   task automatic check_model();
      int unsigned x;
      int unsigned y;
      bit          e_a;
      bit          e_h;
      bit          e_v;
      logic [15:0] e_fc;
      for (int i = 0; i < 2; i++) begin
         x   = pos[i] % ht(i);
         y   = pos[i] / ht(i);
         e_a = (x < ha[i]) && (y < va[i]);
         e_h = ((x >= ha[i] + hf[i]) && (x < ha[i] + hf[i] + hw[i])) ? pol[i] : !pol[i];
         e_v = ((y >= va[i] + vf[i]) && (y < va[i] + vf[i] + vw[i])) ? pol[i] : !pol[i];
`ifdef VGA_FRAME_COUNT_EN
         e_fc = 16'(fcm[i]);
`else
         e_fc = 16'd0;
`endif
         check($sformatf("d%0d_pixel_x", i), 32'(px[i]), x);
         check($sformatf("d%0d_pixel_y", i), 32'(py[i]), y);
         check($sformatf("d%0d_active", i), 32'(act[i]), 32'(e_a));
         check($sformatf("d%0d_hsync", i), 32'(hs[i]), 32'(e_h));
         check($sformatf("d%0d_vsync", i), 32'(vs[i]), 32'(e_v));
         check($sformatf("d%0d_line_start", i), 32'(ls[i]), 32'(m_ls[i]));
         check($sformatf("d%0d_frame_start", i), 32'(fs[i]), 32'(m_fs[i]));
         check($sformatf("d%0d_frame_count", i), 32'(fcnt[i]), 32'(e_fc));
      end
   endtask

   // Inputs change 1 time unit after posedge; outputs sampled at the same point.
   task automatic cycle(input bit ce);
      pix_ce = ce;
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else model_edge(ce);
      check_model();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x"}, 32'(px[0]), 1039);
      check({tag, "_y"}, 32'(py[0]), 665);
      check({tag, "_active"}, 32'(act[0]), 0);
      check({tag, "_hsync"}, 32'(hs[0]), 0);
      check({tag, "_vsync"}, 32'(vs[0]), 0);
      check({tag, "_frame_start"}, 32'(fs[0]), 0);
      check({tag, "_frame_count"}, 32'(fcnt[0]), 0);
   endtask

   vec_t vecs [7];
   int   budget;

   initial begin
      vecs[0] = '{ce: 1'b0, x: 1039, y: 665, a: 1'b0, h: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0};
      vecs[1] = '{ce: 1'b1, x: 0,    y: 0,   a: 1'b1, h: 1'b0, v: 1'b0, l: 1'b1, f: 1'b1};
      vecs[2] = '{ce: 1'b1, x: 1,    y: 0,   a: 1'b1, h: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0};
      vecs[3] = '{ce: 1'b0, x: 1,    y: 0,   a: 1'b1, h: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0};
      vecs[4] = '{ce: 1'b0, x: 1,    y: 0,   a: 1'b1, h: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0};
      vecs[5] = '{ce: 1'b1, x: 2,    y: 0,   a: 1'b1, h: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0};
      vecs[6] = '{ce: 1'b1, x: 3,    y: 0,   a: 1'b1, h: 1'b0, v: 1'b0, l: 1'b0, f: 1'b0};

      reset  = 1'b1;
      pix_ce = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      check_model();
      reset = 1'b0;

      // Post-reset table on the default-timing instance.
      for (int k = 0; k < 7; k++) begin
         cycle(vecs[k].ce);
         check($sformatf("vec%0d_x", k), 32'(px[0]), vecs[k].x);
         check($sformatf("vec%0d_y", k), 32'(py[0]), vecs[k].y);
         check($sformatf("vec%0d_active", k), 32'(act[0]), 32'(vecs[k].a));
         check($sformatf("vec%0d_hsync", k), 32'(hs[0]), 32'(vecs[k].h));
         check($sformatf("vec%0d_vsync", k), 32'(vs[0]), 32'(vecs[k].v));
         check($sformatf("vec%0d_line_start", k), 32'(ls[0]), 32'(vecs[k].l));
         check($sformatf("vec%0d_frame_start", k), 32'(fs[0]), 32'(vecs[k].f));
      end

      // Rest of line 0 up to x=1039; active/hsync windows checked every cycle.
      for (int k = 0; k < 1036; k++) cycle(1'b1);
      check("line0_end_x", 32'(px[0]), 1039);
      check("line0_end_y", 32'(py[0]), 0);

      // Hold at the wrap point: nothing moves, no strobes.
      for (int k = 0; k < 10; k++) begin
         cycle(1'b0);
         check("hold_x", 32'(px[0]), 1039);
         check("hold_line_start", 32'(ls[0]), 0);
         check("hold_frame_start", 32'(fs[0]), 0);
      end
      cycle(1'b1);
      check("wrap_x", 32'(px[0]), 0);
      check("wrap_y", 32'(py[0]), 1);
      check("wrap_line_start", 32'(ls[0]), 1);
      check("wrap_frame_start", 32'(fs[0]), 0);
      cycle(1'b1);
      check("after_wrap_x", 32'(px[0]), 1);
      check("after_wrap_line_start", 32'(ls[0]), 0);

      // Random clock-enable pattern; the small instance runs through many frames.
      for (int k = 0; k < 3000; k++) cycle($urandom_range(0, 3) != 0);

      // Mid-line asynchronous reset at x=400.
      budget = 2000;
      while (px[0] != 11'd400 && budget > 0) begin
         cycle(1'b1);
         budget--;
      end
      check("reach_x400", 32'(px[0]), 400);
      reset = 1'b1;
      #2;
      model_reset();
      check_reset_vals("async_reset");
      check_model();
      cycle(1'b1);
      cycle(1'b1);
      check_reset_vals("reset_held");
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0);
         check("post_reset_no_fs", 32'(fs[0]), 0);
      end
      cycle(1'b1);
      check("post_reset_fs", 32'(fs[0]), 1);
      check("post_reset_x", 32'(px[0]), 0);
      check("post_reset_y", 32'(py[0]), 0);

      // One full frame on the small instance (17 x 12 = 204 pixels) returns to (0,0).
      for (int k = 0; k < 204; k++) cycle(1'b1);
      check("small_frame_x", 32'(px[1]), 0);
      check("small_frame_y", 32'(py[1]), 0);
      check("small_frame_fs", 32'(fs[1]), 1);
`ifdef VGA_FRAME_COUNT_EN
      check("small_frame_count", 32'(fcnt[1]), 1);
`else
      check("small_frame_count", 32'(fcnt[1]), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
